sign_ext_16: RTL and testbench
==============================

Name: sign_ext_16

Overview:
Immediate-extension unit for the MiniRISC datapath. It widens a 16-bit instruction immediate to a 32-bit operand. The default mode is two's-complement sign extension; zero-extend, word-offset and load-upper modes are also provided. It drives a combinational result for same-cycle ALU/branch use, plus a registered copy with valid for pipelined stages.

Parameters:
IN_W, 16, immediate input width; IN_W >= 2.
OUT_W, 32, extended output width; OUT_W >= 2*IN_W so the load-upper result fits.

Ports:
clk  input  1  system clock; registers update on rising edge.
rst_n  input  1  asynchronous active-low reset.
in  input  IN_W  immediate to extend.
mode  input  2  00 sign-extend, 01 zero-extend, 10 sign-extend then shift left 2, 11 load-upper.
in_valid  input  1  qualifies in/mode for the registered path.
out  output  OUT_W  combinational extended result.
is_neg  output  1  combinational; equals in[IN_W-1].
out_q  output  OUT_W  registered copy of out.
out_q_valid  output  1  registered in_valid.

Behaviour:
- One clock; reset is asynchronous and active-low.
- out is purely combinational from in and mode, with zero latency. No clock is required for out to be correct.
- mode 00 (default at power-up benches, including when mode is tied to 0):
  - out[IN_W-1:0] = in.
  - out[OUT_W-1:IN_W] = all copies of in[IN_W-1].
- mode 01: out = in with zeros in the upper bits.
- mode 10: out = (sign-extended in) << 2.
  - The low 2 bits are 0.
  - The top bits shifted out are discarded; no overflow flag.
- mode 11: out[OUT_W-1:OUT_W-IN_W] = in, and the low bits are 0.
- is_neg = in[IN_W-1] regardless of mode.
- Registered path:
  - On a rising clk edge with in_valid=1: out_q <= out, out_q_valid <= 1.
  - On a rising clk edge with in_valid=0: out_q holds its value, out_q_valid <= 0.
  - Latency is 1 cycle.
- Reset:
  - While rst_n=0: out_q=0 and out_q_valid=0, immediately and independent of clk.
  - A reset asserted mid-stream discards the pending value.
  - The first capture after release occurs on the first rising edge with rst_n=1 and in_valid=1.
- Reset has no effect on out or is_neg; they track the inputs combinationally even during reset.
- No X propagation from mode: every encoding is defined.
- Boundary values:
  - in = 0x7FFF gives out = 0x00007FFF.
  - in = 0x8000 gives out = 0xFFFF8000 in mode 00.
  - in = 0xFFFF gives out = 0xFFFFFFFF in mode 00 and 0x0000FFFF in mode 01.

Test Plan:
- mode=00, no clock toggling; apply in = 0, 23, 233, 123, -23 at 100 ns intervals. Required out, in order: 0x00000000, 0x00000017, 0x000000E9, 0x0000007B, 0xFFFFFFE9. is_neg must be 1 only for -23.
- mode=00 boundaries: in=0x7FFF -> 0x00007FFF; in=0x8000 -> 0xFFFF8000; in=0xFFFF -> 0xFFFFFFFF.
- in=0xFFE9 across all modes:
  - mode 01 -> 0x0000FFE9.
  - mode 10 -> 0xFFFFFFA4.
  - mode 11 -> 0xFFE90000.
- Registered path: in=0x0017, mode=00, in_valid=1 for one edge -> next cycle out_q=0x00000017 and out_q_valid=1. With in_valid=0 on the following edge, out_q holds 0x00000017 and out_q_valid=0.
- Reset mid-operation: with out_q=0xFFFFFFE9, drop rst_n between clock edges -> out_q=0 and out_q_valid=0 immediately, while out still equals the combinational value. After release, the next valid edge captures correctly.
- mode=10 with in=0x8000 -> out=0xFFFE0000; with in=0x4000 -> out=0x00010000.

Source files
------------

// File: rtl/sign_ext_16.sv
// Immediate extension unit: widens an instruction immediate to a datapath operand.
// Combinational result for same-cycle use plus a registered copy with valid.
`timescale 1ns/1ps
module sign_ext_16 #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic [OUT_W-1:0] out,
  output logic             is_neg,
  output logic [OUT_W-1:0] out_q,
  output logic             out_q_valid
);

  localparam int PAD_W = OUT_W - IN_W;

  logic             w_sign;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_word;
  logic [OUT_W-1:0] w_upper;
  logic [OUT_W-1:0] w_out;

  logic [OUT_W-1:0] r_out_q;
  logic             r_out_q_valid;

  assign w_sign  = in[IN_W-1];
  assign w_sext  = {{PAD_W{w_sign}}, in};
  assign w_zext  = {{PAD_W{1'b0}}, in};
  // Bits shifted past the top are dropped; no overflow reporting.
  assign w_word  = w_sext << 2;
  assign w_upper = {in, {PAD_W{1'b0}}};

  always_comb begin
    w_out = w_sext;
    unique case (mode)
      2'b00: w_out = w_sext;
      2'b01: w_out = w_zext;
      2'b10: w_out = w_word;
      2'b11: w_out = w_upper;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_q       <= '0;
      r_out_q_valid <= 1'b0;
    end else begin
      r_out_q_valid <= in_valid;
      if (in_valid) begin
        r_out_q <= w_out;
      end
    end
  end

  assign out         = w_out;
  assign is_neg      = w_sign;
  assign out_q       = r_out_q;
  assign out_q_valid = r_out_q_valid;

endmodule

// File: tb/tb_sign_ext_16.sv
// Directed bench for sign_ext_16: vector table for the combinational
// path, hand sequences for the registered path and reset.
`timescale 1ns/1ps
module tb_sign_ext_16;

  logic        clk;
  logic        rst_n;
  logic [15:0] in;
  logic [1:0]  mode;
  logic        in_valid;
  logic [31:0] out;
  logic        is_neg;
  logic [31:0] out_q;
  logic        out_q_valid;

  int errors = 0;
  int checks = 0;

  sign_ext_16 #(.IN_W(16), .OUT_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in          (in),
    .mode        (mode),
    .in_valid    (in_valid),
    .out         (out),
    .is_neg      (is_neg),
    .out_q       (out_q),
    .out_q_valid (out_q_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] in;
    logic [1:0]  mode;
    logic [31:0] exp_out;
    logic        exp_neg;
  } vec_t;

  vec_t vecs [15];

  task automatic chk32(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{16'h0000, 2'b00, 32'h0000_0000, 1'b0};
    vecs[1]  = '{16'h0017, 2'b00, 32'h0000_0017, 1'b0};
    vecs[2]  = '{16'h00E9, 2'b00, 32'h0000_00E9, 1'b0};
    vecs[3]  = '{16'h007B, 2'b00, 32'h0000_007B, 1'b0};
    vecs[4]  = '{16'hFFE9, 2'b00, 32'hFFFF_FFE9, 1'b1};
    vecs[5]  = '{16'h7FFF, 2'b00, 32'h0000_7FFF, 1'b0};
    vecs[6]  = '{16'h8000, 2'b00, 32'hFFFF_8000, 1'b1};
    vecs[7]  = '{16'hFFFF, 2'b00, 32'hFFFF_FFFF, 1'b1};
    vecs[8]  = '{16'hFFFF, 2'b01, 32'h0000_FFFF, 1'b1};
    vecs[9]  = '{16'hFFE9, 2'b01, 32'h0000_FFE9, 1'b1};
    vecs[10] = '{16'hFFE9, 2'b10, 32'hFFFF_FFA4, 1'b1};
    vecs[11] = '{16'hFFE9, 2'b11, 32'hFFE9_0000, 1'b1};
    vecs[12] = '{16'h8000, 2'b10, 32'hFFFE_0000, 1'b1};
    vecs[13] = '{16'h4000, 2'b10, 32'h0001_0000, 1'b0};
    vecs[14] = '{16'h0001, 2'b11, 32'h0001_0000, 1'b0};

    rst_n    = 1'b0;
    in       = '0;
    mode     = 2'b00;
    in_valid = 1'b0;
    #1;
    chk32("reset_out_q", out_q, 32'h0);
    chk1("reset_out_q_valid", out_q_valid, 1'b0);
    chk32("comb_during_reset", out, 32'h0);
    in = 16'hFFE9;
    #1;
    chk32("comb_during_reset_neg", out, 32'hFFFF_FFE9);
    chk1("is_neg_during_reset", is_neg, 1'b1);

    for (int i = 0; i < 15; i++) begin
      in   = vecs[i].in;
      mode = vecs[i].mode;
      #100;
      chk32($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
      chk1($sformatf("vec%0d_is_neg", i), is_neg, vecs[i].exp_neg);
    end

    // Registered path: capture then hold
    @(negedge clk);
    rst_n    = 1'b1;
    in       = 16'h0017;
    mode     = 2'b00;
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk32("cap_out_q", out_q, 32'h0000_0017);
    chk1("cap_valid", out_q_valid, 1'b1);
    in_valid = 1'b0;
    in       = 16'h1234;
    @(posedge clk); #1;
    chk32("hold_out_q", out_q, 32'h0000_0017);
    chk1("hold_valid", out_q_valid, 1'b0);

    // Reset mid-operation
    @(negedge clk);
    in       = 16'hFFE9;
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk32("pre_rst_out_q", out_q, 32'hFFFF_FFE9);
    chk1("pre_rst_valid", out_q_valid, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk32("async_rst_out_q", out_q, 32'h0);
    chk1("async_rst_valid", out_q_valid, 1'b0);
    chk32("async_rst_comb", out, 32'hFFFF_FFE9);
    @(posedge clk); #1;
    chk32("rst_held_out_q", out_q, 32'h0);
    chk1("rst_held_valid", out_q_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    in    = 16'h7FFF;
    mode  = 2'b11;
    @(posedge clk); #1;
    chk32("post_rst_out_q", out_q, 32'h7FFF_0000);
    chk1("post_rst_valid", out_q_valid, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
